// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI write-path arbiter: index/count widths and the AW FSM states.
// The default geometry here is what axi_wr_arbiter uses unless overridden.
package axi_arb_pkg;

  localparam int DEF_INPUT_NUM       = 2;
  localparam int DEF_MAX_OUTSTANDING = 4;

  localparam int IDX_W = (DEF_INPUT_NUM > 1) ? $clog2(DEF_INPUT_NUM) : 1;
  localparam int CNT_W = $clog2(DEF_MAX_OUTSTANDING + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    AW_IDLE,
    AW_PEND
  } aw_state_e;

endpackage

// File: rtl/arb_idx_fifo.sv
// Small synchronous FIFO of master indices; a push and a pop may share an edge, even when full.
// Used twice by the arbiter: AW->W ordering and W->B ordering.
module arb_idx_fifo
  import axi_arb_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge ACLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Write-path scheduler for an N:1 AXI mux: round-robin AW arbitration, in-order W routing,
// and B responses returned to their owners. Only one-hot selects leave this block.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int INPUT_NUM       = DEF_INPUT_NUM,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [INPUT_NUM-1:0] s_awvalid,
  output logic [INPUT_NUM-1:0] s_awready,
  output logic [INPUT_NUM-1:0] aw_grant,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  input  logic [INPUT_NUM-1:0] s_wvalid,
  input  logic [INPUT_NUM-1:0] s_wlast,
  output logic [INPUT_NUM-1:0] s_wready,
  output logic [INPUT_NUM-1:0] w_sel,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  input  logic                 m_bvalid,
  output logic                 m_bready,
  output logic [INPUT_NUM-1:0] s_bvalid,
  input  logic [INPUT_NUM-1:0] s_bready,
  output logic                 err_stray_b
);

  localparam int IW = $clog2(INPUT_NUM);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  aw_state_e      state;
  logic [IW-1:0]  win_idx;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  rr_next;
  logic [IW-1:0]  aw_pick;
  logic [CW-1:0]  cnt;
  logic           aw_blocked;
  logic           aw_hs;
  logic           w_last_hs;
  logic           b_hs;

  logic [IW-1:0]  w_head;
  logic           w_full;
  logic           w_empty;
  logic [IW-1:0]  b_head;
  logic           b_full;
  logic           b_empty;
  logic [INPUT_NUM-1:0] b_sel;

  // First requester at or after ptr, scanning upward with wrap to 0.
  function automatic logic [IW-1:0] rr_pick(input logic [INPUT_NUM-1:0] req,
                                             input logic [IW-1:0]        ptr);
    logic [IW-1:0] pick;
    logic          found;
    int            cand;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      cand = int'(ptr) + i;
      if (cand >= INPUT_NUM) begin
        cand = cand - INPUT_NUM;
      end
      if (!found && req[IW'(cand)]) begin
        pick  = IW'(cand);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [INPUT_NUM-1:0] onehot(input logic [IW-1:0] idx);
    logic [INPUT_NUM-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign aw_pick    = rr_pick(s_awvalid, rr_ptr);
  assign rr_next    = (win_idx == IW'(INPUT_NUM - 1)) ? '0 : win_idx + 1'b1;
  assign aw_blocked = (cnt == CW'(MAX_OUTSTANDING)) || w_full;

  assign m_awvalid  = (state == AW_PEND);
  assign s_awready  = aw_grant & {INPUT_NUM{m_awready}};
  assign aw_hs      = m_awvalid && m_awready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= AW_IDLE;
      aw_grant <= '0;
      win_idx  <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        AW_IDLE: begin
          if (!aw_blocked && (|s_awvalid)) begin
            win_idx  <= aw_pick;
            aw_grant <= onehot(aw_pick);
            state    <= AW_PEND;
          end
        end
        // The winner stays granted until the slave accepts, even if it drops AWVALID.
        AW_PEND: begin
          if (m_awready) begin
            rr_ptr   <= rr_next;
            aw_grant <= '0;
            state    <= AW_IDLE;
          end
        end
        default: begin
          aw_grant <= '0;
          state    <= AW_IDLE;
        end
      endcase
    end
  end

  assign w_sel     = w_empty ? '0 : onehot(w_head);
  assign m_wvalid  = |(s_wvalid & w_sel);
  assign s_wready  = w_sel & {INPUT_NUM{m_wready}};
  assign w_last_hs = m_wvalid && m_wready && (|(s_wlast & w_sel)) && (!b_full || b_hs);

  arb_idx_fifo #(
    .WIDTH (IW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_wfifo (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .push      (aw_hs),
    .push_data (win_idx),
    .pop       (w_last_hs),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  arb_idx_fifo #(
    .WIDTH (IW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_bfifo (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .push      (w_last_hs),
    .push_data (w_head),
    .pop       (b_hs),
    .head      (b_head),
    .full      (b_full),
    .empty     (b_empty)
  );

  assign b_sel    = b_empty ? '0 : onehot(b_head);
  assign s_bvalid = b_sel & {INPUT_NUM{m_bvalid}};
  assign m_bready = |(s_bready & b_sel);
  assign b_hs     = m_bvalid && m_bready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt <= '0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A response with nobody waiting for it means the slave and this block disagree.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      err_stray_b <= 1'b0;
    end else if (m_bvalid && b_empty) begin
      err_stray_b <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized bench for axi_wr_arbiter against a queue-based transaction model.
// Inputs change on the falling edge; outputs are compared just after, before the rising edge.
module tb_axi_wr_arbiter;

  localparam int N   = 2;
  localparam int MAX = 4;

  logic         ACLK;
  logic         ARESET;
  logic [N-1:0] s_awvalid;
  logic [N-1:0] s_awready;
  logic [N-1:0] aw_grant;
  logic         m_awvalid;
  logic         m_awready;
  logic [N-1:0] s_wvalid;
  logic [N-1:0] s_wlast;
  logic [N-1:0] s_wready;
  logic [N-1:0] w_sel;
  logic         m_wvalid;
  logic         m_wready;
  logic         m_bvalid;
  logic         m_bready;
  logic [N-1:0] s_bvalid;
  logic [N-1:0] s_bready;
  logic         err_stray_b;

  axi_wr_arbiter #(
    .INPUT_NUM       (N),
    .MAX_OUTSTANDING (MAX)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .s_awvalid   (s_awvalid),
    .s_awready   (s_awready),
    .aw_grant    (aw_grant),
    .m_awvalid   (m_awvalid),
    .m_awready   (m_awready),
    .s_wvalid    (s_wvalid),
    .s_wlast     (s_wlast),
    .s_wready    (s_wready),
    .w_sel       (w_sel),
    .m_wvalid    (m_wvalid),
    .m_wready    (m_wready),
    .m_bvalid    (m_bvalid),
    .m_bready    (m_bready),
    .s_bvalid    (s_bvalid),
    .s_bready    (s_bready),
    .err_stray_b (err_stray_b)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Model: master holding the AW grant (-1 if none), rr start point, outstanding count,
  // masters owed W bursts in order, masters owed B responses in order, sticky stray flag.
  int pend;
  int rr;
  int cnt;
  int wq[$];
  int bq[$];
  bit err;

  int checks;
  int failures;

  function automatic logic [N-1:0] bitOf(input int i);
    return N'(1 << i);
  endfunction

  function automatic logic rnd(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  function automatic logic [N-1:0] rndVec(input int pct);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) begin
      v[i] = rnd(pct);
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    pend = -1;
    rr   = 0;
    cnt  = 0;
    wq.delete();
    bq.delete();
    err  = 1'b0;
  endtask

  task automatic applyStimulus(input logic rst, input logic [N-1:0] awv, input logic awr,
                               input logic [N-1:0] wv, input logic [N-1:0] wl, input logic wr,
                               input logic bv, input logic [N-1:0] br);
    logic [N-1:0] eGrant;
    logic [N-1:0] eWsel;
    logic [N-1:0] eBsel;
    logic         eMwv;
    bit           wDone;
    bit           bHs;
    int           idx;
    int           cand;
    @(negedge ACLK);
    ARESET    = rst;
    s_awvalid = awv;
    m_awready = awr;
    s_wvalid  = wv;
    s_wlast   = wl;
    m_wready  = wr;
    m_bvalid  = bv;
    s_bready  = br;
    #1;
    eGrant = (pend >= 0) ? bitOf(pend) : '0;
    eWsel  = (wq.size() > 0) ? bitOf(wq[0]) : '0;
    eBsel  = (bq.size() > 0) ? bitOf(bq[0]) : '0;
    eMwv   = |(wv & eWsel);
    checkOutput("aw_grant",    32'(aw_grant),    32'(eGrant));
    checkOutput("m_awvalid",   32'(m_awvalid),   32'(pend >= 0));
    checkOutput("s_awready",   32'(s_awready),   32'(awr ? eGrant : '0));
    checkOutput("w_sel",       32'(w_sel),       32'(eWsel));
    checkOutput("m_wvalid",    32'(m_wvalid),    32'(eMwv));
    checkOutput("s_wready",    32'(s_wready),    32'(wr ? eWsel : '0));
    checkOutput("s_bvalid",    32'(s_bvalid),    32'(bv ? eBsel : '0));
    checkOutput("m_bready",    32'(m_bready),    32'(|(br & eBsel)));
    checkOutput("err_stray_b", 32'(err_stray_b), 32'(err));

    wDone = (wq.size() > 0) && eMwv && wr && ((wl & eWsel) != '0);
    bHs   = (bq.size() > 0) && bv && ((br & eBsel) != '0);
    if (rst) begin
      modelReset();
    end else begin
      if (bv && bq.size() == 0) err = 1'b1;
      if (bHs) void'(bq.pop_front());
      if (wDone) begin
        idx = wq.pop_front();
        bq.push_back(idx);
      end
      if (pend >= 0) begin
        if (awr) begin
          wq.push_back(pend);
          cnt++;
          rr   = (pend + 1) % N;
          pend = -1;
        end
      end else if (cnt < MAX && awv != '0) begin
        for (int k = 0; k < N; k++) begin
          cand = (rr + k) % N;
          if (pend < 0 && ((awv >> cand) & 1) != 0) pend = cand;
        end
      end
      if (bHs) cnt--;
    end
  endtask

  int awP[6]   = '{50, 90, 80, 30, 70, 100};
  int awrP[6]  = '{70, 30, 90, 50, 60, 100};
  int wP[6]    = '{70, 50, 90, 60, 80, 100};
  int lastP[6] = '{40, 50, 30, 80, 50, 100};
  int wrP[6]   = '{70, 50, 90, 60, 80, 100};
  int bvP[6]   = '{30, 10, 70, 50, 40, 100};
  int brP[6]   = '{80, 50, 90, 60, 70, 100};
  int rstP[6]  = '{0, 0, 0, 0, 2, 0};

  initial begin
    checks   = 0;
    failures = 0;
    modelReset();
    ARESET    = 1'b1;
    s_awvalid = '0;
    m_awready = 1'b0;
    s_wvalid  = '0;
    s_wlast   = '0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    s_bready  = '0;

    applyStimulus(1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 2'b00);
    applyStimulus(1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 2'b00);
    applyStimulus(0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 2'b00);
    checkOutput("rst_grant", 32'(aw_grant), 32'd0);
    checkOutput("rst_err",   32'(err_stray_b), 32'd0);

    // Single m0 transaction: AW, one-beat W, B.
    applyStimulus(0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 2'b00);
    checkOutput("aw_lat0", 32'(m_awvalid), 32'd0);
    applyStimulus(0, 2'b01, 1, 2'b00, 2'b00, 0, 0, 2'b00);
    checkOutput("aw_lat1", 32'(m_awvalid), 32'd1);
    checkOutput("m0_grant", 32'(aw_grant), 32'd1);
    applyStimulus(0, 2'b00, 0, 2'b01, 2'b01, 1, 0, 2'b00);
    checkOutput("m0_wsel", 32'(w_sel), 32'd1);
    applyStimulus(0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 2'b01);
    checkOutput("m0_bvalid", 32'(s_bvalid), 32'd1);

    // Stray response sets the sticky flag; only reset clears it.
    applyStimulus(0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 2'b11);
    checkOutput("stray_bready", 32'(m_bready), 32'd0);
    applyStimulus(0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 2'b00);
    checkOutput("stray_err", 32'(err_stray_b), 32'd1);
    applyStimulus(1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 2'b00);
    applyStimulus(0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 2'b00);
    checkOutput("stray_clr", 32'(err_stray_b), 32'd0);

    // Held grant while the slave stalls, then round-robin moves to m1.
    applyStimulus(0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 2'b11, 0, 2'b00, 2'b00, 0, 0, 2'b00);
      checkOutput("stall_grant", 32'(aw_grant), 32'd1);
    end
    applyStimulus(0, 2'b11, 1, 2'b00, 2'b00, 0, 0, 2'b00);
    applyStimulus(0, 2'b11, 0, 2'b00, 2'b00, 0, 0, 2'b00);
    applyStimulus(0, 2'b11, 0, 2'b00, 2'b00, 0, 0, 2'b00);
    checkOutput("rr_next", 32'(aw_grant), 32'd2);

    for (int ph = 0; ph < 6; ph++) begin
      applyStimulus(1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 2'b00);
      for (int c = 0; c < 400; c++) begin
        applyStimulus(rnd(rstP[ph]), rndVec(awP[ph]), rnd(awrP[ph]), rndVec(wP[ph]),
                      rndVec(lastP[ph]), rnd(wrP[ph]), rnd(bvP[ph]), rndVec(brP[ph]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
